// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a req/ack data-memory handshake: store lane steering,
// load extraction, misalignment and bus-timeout exceptions, and the MEM/WB register.
`timescale 1ns/1ps
module mem_stage_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [DATA_W-1:0]    ex_alu_result,
  input  logic [DATA_W-1:0]    ex_rs2_data,
  input  logic [4:0]           ex_rd_adr,
  input  logic                 ex_RegWrite,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [1:0]           ex_size,
  input  logic                 ex_unsigned,
  output logic [DATA_W-1:0]    mem_stage_alu_result,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]    dmem_wdata,
  output logic [DATA_W/8-1:0]  dmem_wstrb,
  input  logic                 dmem_ack,
  input  logic [DATA_W-1:0]    dmem_rdata,
  output logic                 mem_wb_valid,
  output logic [4:0]           mem_wb_rd_adr,
  output logic                 mem_wb_RegWrite,
  output logic [DATA_W-1:0]    mem_wb_result,
  output logic                 mem_wb_exc,
  output logic [1:0]           mem_wb_exc_cause
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_LD_MA = 2'b01;
  localparam logic [1:0] CAUSE_ST_MA = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  function automatic logic misaligned(input logic [OFS_W-1:0] ofs, input logic [1:0] size);
    int nb;
    nb = 1 << size;
    return (nb > STRB_W) || ((int'(ofs) & (nb - 1)) != 0);
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [DATA_W-1:0] rs2,
                                                   input logic [1:0] size);
    logic [DATA_W-1:0] w;
    int nb;
    nb = 1 << size;
    if (nb > STRB_W) nb = STRB_W;
    for (int i = 0; i < STRB_W; i++) w[8*i +: 8] = rs2[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [STRB_W-1:0] store_strb(input logic [OFS_W-1:0] ofs,
                                                   input logic [1:0] size);
    logic [STRB_W-1:0] s;
    int nb;
    int o;
    nb = 1 << size;
    o  = int'(ofs);
    for (int i = 0; i < STRB_W; i++) s[i] = (i >= o) && (i < o + nb);
    return s;
  endfunction

  // Shift the addressed bytes to lane 0, then left/right shift to truncate and extend.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                 input logic [OFS_W-1:0] ofs,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic signed [DATA_W-1:0] t;
    int sh;
    sh = DATA_W - 8 * (1 << size);
    if (sh < 0) sh = 0;
    t = rdata >> (8 * int'(ofs));
    t = t << sh;
    if (uns) t = t >> sh;
    else     t = t >>> sh;
    return t;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [STRB_W-1:0]   dmem_wstrb_q, dmem_wstrb_d;
  logic [4:0]          lat_rd_q, lat_rd_d;
  logic                lat_rw_q, lat_rw_d;
  logic [1:0]          lat_size_q, lat_size_d;
  logic                lat_uns_q, lat_uns_d;
  logic [OFS_W-1:0]    lat_ofs_q, lat_ofs_d;
  logic                lat_st_q, lat_st_d;
  logic [DATA_W-1:0]   lat_addr_q, lat_addr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic                wb_rw_q, wb_rw_d;
  logic [DATA_W-1:0]   wb_result_q, wb_result_d;
  logic                wb_exc_q, wb_exc_d;
  logic [1:0]          wb_cause_q, wb_cause_d;

  logic                accept;
  logic                is_mem;
  logic [ADDR_W-1:0]   ex_addr;
  logic [ADDR_W-1:0]   ex_addr_al;
  logic [OFS_W-1:0]    ex_ofs;
  logic                ex_mis;

  always_comb begin
    ex_addr                = ex_alu_result[ADDR_W-1:0];
    ex_ofs                 = ex_addr[OFS_W-1:0];
    ex_addr_al             = ex_addr;
    ex_addr_al[OFS_W-1:0]  = '0;
    is_mem                 = ex_mem_read | ex_mem_write;
    ex_mis                 = misaligned(ex_ofs, ex_size);
    accept                 = ex_valid & (state_q == S_IDLE);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    lat_rd_d     = lat_rd_q;
    lat_rw_d     = lat_rw_q;
    lat_size_d   = lat_size_q;
    lat_uns_d    = lat_uns_q;
    lat_ofs_d    = lat_ofs_q;
    lat_st_d     = lat_st_q;
    lat_addr_d   = lat_addr_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_rw_d      = wb_rw_q;
    wb_result_d  = wb_result_q;
    wb_exc_d     = wb_exc_q;
    wb_cause_d   = wb_cause_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem || ex_mis) begin
            // Non-memory ops and misaligned accesses retire directly, no bus traffic.
            wb_valid_d  = 1'b1;
            wb_rd_d     = ex_rd_adr;
            wb_rw_d     = is_mem ? 1'b0 : ex_RegWrite;
            wb_result_d = ex_alu_result;
            wb_exc_d    = is_mem;
            wb_cause_d  = !is_mem ? CAUSE_NONE : (ex_mem_write ? CAUSE_ST_MA : CAUSE_LD_MA);
          end else begin
            lat_rd_d     = ex_rd_adr;
            lat_rw_d     = ex_RegWrite;
            lat_size_d   = ex_size;
            lat_uns_d    = ex_unsigned;
            lat_ofs_d    = ex_ofs;
            lat_st_d     = ex_mem_write;
            lat_addr_d   = ex_alu_result;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_mem_write;
            dmem_addr_d  = ex_addr_al;
            dmem_wdata_d = ex_mem_write ? store_data(ex_rs2_data, ex_size) : '0;
            dmem_wstrb_d = ex_mem_write ? store_strb(ex_ofs, ex_size) : '0;
            cnt_d        = '0;
            state_d      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (dmem_ack) begin
          wb_valid_d  = 1'b1;
          wb_rd_d     = lat_rd_q;
          wb_rw_d     = lat_rw_q;
          wb_result_d = lat_st_q ? lat_addr_q
                                 : load_ext(dmem_rdata, lat_ofs_q, lat_size_q, lat_uns_q);
          wb_exc_d    = 1'b0;
          wb_cause_d  = CAUSE_NONE;
          dmem_req_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wb_valid_d  = 1'b1;
          wb_rd_d     = lat_rd_q;
          wb_rw_d     = 1'b0;
          wb_result_d = lat_addr_q;
          wb_exc_d    = 1'b1;
          wb_cause_d  = CAUSE_TMO;
          dmem_req_d  = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: bus request registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
      lat_rd_q     <= '0;
      lat_rw_q     <= 1'b0;
      lat_size_q   <= '0;
      lat_uns_q    <= 1'b0;
      lat_ofs_q    <= '0;
      lat_st_q     <= 1'b0;
      lat_addr_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_rw_q      <= 1'b0;
      wb_result_q  <= '0;
      wb_exc_q     <= 1'b0;
      wb_cause_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      lat_rd_q     <= lat_rd_d;
      lat_rw_q     <= lat_rw_d;
      lat_size_q   <= lat_size_d;
      lat_uns_q    <= lat_uns_d;
      lat_ofs_q    <= lat_ofs_d;
      lat_st_q     <= lat_st_d;
      lat_addr_q   <= lat_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_rw_q      <= wb_rw_d;
      wb_result_q  <= wb_result_d;
      wb_exc_q     <= wb_exc_d;
      wb_cause_q   <= wb_cause_d;
    end
  end

  assign ex_ready             = (state_q == S_IDLE);
  assign mem_stage_alu_result = ex_alu_result;
  assign dmem_req             = dmem_req_q;
  assign dmem_we              = dmem_we_q;
  assign dmem_addr            = dmem_addr_q;
  assign dmem_wdata           = dmem_wdata_q;
  assign dmem_wstrb           = dmem_wstrb_q;
  assign mem_wb_valid         = wb_valid_q;
  assign mem_wb_rd_adr        = wb_rd_q;
  assign mem_wb_RegWrite      = wb_rw_q;
  assign mem_wb_result        = wb_result_q;
  assign mem_wb_exc           = wb_exc_q;
  assign mem_wb_exc_cause     = wb_cause_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus randomized memory/non-memory ops
// compared against an arithmetic reference model of the stage's rules.
`timescale 1ns/1ps
module tb_mem_stage_hs;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [4:0]  ex_rd_adr = '0;
  logic        ex_RegWrite = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_size = '0;
  logic        ex_unsigned = 1'b0;
  logic [31:0] mem_stage_alu_result;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd_adr;
  logic        mem_wb_RegWrite;
  logic [31:0] mem_wb_result;
  logic        mem_wb_exc;
  logic [1:0]  mem_wb_exc_cause;

  int checks = 0;
  int errors = 0;

  mem_stage_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_rd_adr(ex_rd_adr), .ex_RegWrite(ex_RegWrite),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .mem_stage_alu_result(mem_stage_alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd_adr(mem_wb_rd_adr),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_result(mem_wb_result),
    .mem_wb_exc(mem_wb_exc), .mem_wb_exc_cause(mem_wb_exc_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: load value = selected bytes of rdata, as an integer, optionally sign-extended.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                           input int nb, input logic uns);
    longint v, full;
    full = longint'(1) << (8 * nb);
    v = (longint'(rdata) / (longint'(1) << (8 * off))) % full;
    if (!uns && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  // Reference: low nb bytes of rs2 repeated across the word.
  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input int nb);
    longint pat;
    pat = longint'(rs2) % (longint'(1) << (8 * nb));
    if (nb == 1) return 32'(pat * 64'h0101_0101);
    if (nb == 2) return 32'(pat * 64'h0001_0001);
    return 32'(pat);
  endfunction

  // kind: 0 non-memory, 1 load, 2 store, 3 load+store (store wins).
  // ack_at: request cycle (1-based) in which dmem_ack is raised; > TIMEOUT means never.
  task automatic run_op(input int kind, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input int ack_at, input logic [31:0] rdata);
    int off, nb;
    logic is_mem, is_st, mis;
    off    = int'(addr % 4);
    nb     = 1 << sz;
    is_mem = (kind != 0);
    is_st  = (kind >= 2);
    mis    = is_mem && (nb > 4 || (off % nb) != 0);
    chk("ready_idle", ex_ready, 1);
    ex_valid      = 1'b1;
    ex_alu_result = addr;
    ex_rs2_data   = rs2;
    ex_rd_adr     = rd;
    ex_RegWrite   = rw;
    ex_mem_read   = (kind == 1 || kind == 3);
    ex_mem_write  = is_st;
    ex_size       = sz;
    ex_unsigned   = uns;
    #1;
    chk("fwd_alu", mem_stage_alu_result, addr);
    step();
    ex_valid      = 1'b0;
    ex_alu_result = $urandom;
    ex_rs2_data   = $urandom;
    ex_rd_adr     = 5'($urandom);
    if (!is_mem || mis) begin
      chk("direct_valid", mem_wb_valid, 1);
      chk("direct_req", dmem_req, 0);
      chk("direct_result", mem_wb_result, addr);
      chk("direct_rd", mem_wb_rd_adr, rd);
      chk("direct_regwrite", mem_wb_RegWrite, is_mem ? 0 : rw);
      chk("direct_exc", mem_wb_exc, mis);
      chk("direct_cause", mem_wb_exc_cause, !mis ? 0 : (is_st ? 2 : 1));
      chk("direct_ready", ex_ready, 1);
      step();
      chk("direct_pulse_end", mem_wb_valid, 0);
      return;
    end
    for (int c = 1; c <= TIMEOUT; c++) begin
      chk("wait_req", dmem_req, 1);
      chk("wait_ready", ex_ready, 0);
      chk("wait_novalid", mem_wb_valid, 0);
      if (c == 1) begin
        chk("bus_we", dmem_we, is_st);
        chk("bus_addr", dmem_addr, addr - 32'(off));
        chk("bus_wstrb", dmem_wstrb, is_st ? ((1 << nb) - 1) << off : 0);
        if (is_st) chk("bus_wdata", dmem_wdata, ref_wdata(rs2, nb));
      end
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdata : $urandom;
      step();
      if (c == ack_at || c == TIMEOUT) begin
        dmem_ack = 1'b0;
        chk("ret_valid", mem_wb_valid, 1);
        chk("ret_req_drop", dmem_req, 0);
        chk("ret_ready", ex_ready, 1);
        chk("ret_rd", mem_wb_rd_adr, rd);
        if (c == ack_at) begin
          chk("ret_exc", mem_wb_exc, 0);
          chk("ret_cause", mem_wb_exc_cause, 0);
          chk("ret_regwrite", mem_wb_RegWrite, rw);
          chk("ret_result", mem_wb_result, is_st ? addr : ref_load(rdata, off, nb, uns));
        end else begin
          chk("tmo_exc", mem_wb_exc, 1);
          chk("tmo_cause", mem_wb_exc_cause, 3);
          chk("tmo_regwrite", mem_wb_RegWrite, 0);
        end
        break;
      end
    end
    step();
    chk("ret_pulse_end", mem_wb_valid, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wb", {mem_wb_valid, mem_wb_rd_adr, mem_wb_RegWrite, mem_wb_exc, mem_wb_exc_cause}, 0);
    chk("rst_wb_result", mem_wb_result, 0);
    rst = 1'b0;
    step();

    run_op(0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1, 32'h0);
    run_op(1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_FFFF);
    run_op(1, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_FFFF);
    run_op(2, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 1'b0, 1, 32'h0);
    run_op(1, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    run_op(2, 2'b10, 1'b0, 32'h0000_3002, 32'h1, 5'd0, 1'b0, 1, 32'h0);
    run_op(1, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 5'd3, 1'b1, 1, 32'h0);
    run_op(1, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd4, 1'b1, TIMEOUT + 1, 32'h0);
    run_op(1, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd4, 1'b1, TIMEOUT, 32'hCAFE_F00D);
    run_op(1, 2'b01, 1'b0, 32'h0000_6002, 32'h0, 5'd6, 1'b1, 2, 32'h8001_7FFF);

    // Spurious ack while idle must not retire or request.
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("spurious_valid", mem_wb_valid, 0);
    chk("spurious_req", dmem_req, 0);

    // Reset during the second wait cycle, ack one cycle later.
    ex_valid = 1'b1; ex_alu_result = 32'h0000_7004; ex_rd_adr = 5'd11; ex_RegWrite = 1'b1;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'b10; ex_unsigned = 1'b0;
    step();
    ex_valid = 1'b0;
    chk("rstw_req1", dmem_req, 1);
    step();
    chk("rstw_req2", dmem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_2222;
    chk("rstw_req_drop", dmem_req, 0);
    chk("rstw_novalid", mem_wb_valid, 0);
    chk("rstw_ready", ex_ready, 1);
    step();
    dmem_ack = 1'b0;
    chk("rstw_late_ack", mem_wb_valid, 0);
    chk("rstw_late_req", dmem_req, 0);
    step();

    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom), $urandom, $urandom,
             5'($urandom), 1'($urandom), int'($urandom_range(1, TIMEOUT + 1)), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation MEM stage of the RISC-V core pipeline; sits between the EX/MEM register and the WB stage.
- Replaces the single-cycle, always-ready data-memory interface with a req/ack handshake that tolerates variable wait states.
- Performs store byte-lane steering, load extraction with sign/zero extension, misalignment detection and bus-timeout detection.
- Owns the MEM/WB pipeline register and stalls upstream while an access is outstanding.

Parameters:
- DATA_W, 32, data-bus and register width; legal values 32 or 64; STRB_W = DATA_W/8, OFS_W = log2(STRB_W).
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum cycles dmem_req may be held without dmem_ack before a bus-timeout exception; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock clk, reset rst is synchronous and active-high.
- ex_valid  in  1  EX/MEM register holds an instruction.
- ex_ready  out  1  stage accepts the instruction this cycle; equals (state==IDLE).
- ex_alu_result  in  DATA_W  ALU result / effective byte address (low ADDR_W bits used).
- ex_rs2_data  in  DATA_W  store data.
- ex_rd_adr  in  5  destination register.
- ex_RegWrite  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store; has priority if ex_mem_read is also set.
- ex_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- ex_unsigned  in  1  zero-extend the load (LBU/LHU/LWU).
- mem_stage_alu_result  out  DATA_W  combinational copy of ex_alu_result, for forwarding.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  write enable, registered.
- dmem_addr  out  ADDR_W  address aligned down to STRB_W.
- dmem_wdata  out  DATA_W  store data replicated across lanes.
- dmem_wstrb  out  STRB_W  byte strobes; all zero on reads.
- dmem_ack  in  1  access complete; rdata valid for reads.
- dmem_rdata  in  DATA_W  read data.
- mem_wb_valid  out  1  one-cycle pulse per retired instruction.
- mem_wb_rd_adr  out  5  destination register.
- mem_wb_RegWrite  out  1  forced to 0 on any exception.
- mem_wb_result  out  DATA_W  extended load data, or ALU result for non-loads.
- mem_wb_exc  out  1  exception flag.
- mem_wb_exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout, 00 none.

Behaviour:
- Reset: state IDLE, so ex_ready=1. dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb = 0. All mem_wb_* = 0. Timeout counter = 0.
- Reset in WAIT abandons the access: dmem_req=0 on the next cycle, no retirement; a late ack is ignored.
- Accept means ex_valid & ex_ready.
- Alignment: offset = addr[OFS_W-1:0].
  - Misaligned when byte-size in bytes does not divide offset.
  - ex_size=11 with DATA_W=32 is also treated as misaligned.
- Non-memory op accepted: on the next edge load the MEM/WB registers (latency 1), mem_wb_result=ex_alu_result, mem_wb_valid=1, stay in IDLE.
- Misaligned memory op accepted:
  - No dmem request is issued.
  - Retire at latency 1 with mem_wb_exc=1, cause 01 (load) or 10 (store), mem_wb_RegWrite=0, mem_wb_result=ex_alu_result (faulting address).
- Aligned memory op accepted:
  - Latch rd, RegWrite, size, unsigned, offset and the op into internal registers.
  - Drive dmem_req=1, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb from registers on the next edge; go to WAIT.
- Store data and strobes: wstrb = ({1,2,4,8} ones by size) << offset; wdata = rs2 low bytes replicated across all lanes.
- WAIT state:
  - dmem_* outputs are held stable and ex_ready=0.
  - Each cycle with dmem_req=1 and dmem_ack=0 increments the counter.
- WAIT, dmem_ack=1:
  - On that edge, retire to MEM/WB with mem_wb_valid=1 and deassert dmem_req (registered 0 next cycle); go to IDLE.
  - An ack in the first req cycle is legal, giving minimum memory-op latency 2.
- Load result: (dmem_rdata >> 8*offset) truncated to size, then sign-extended unless ex_unsigned; word/dword loads use the full lane.
- Store retire: mem_wb_result = address, RegWrite as latched (0 from decode).
- Timeout: if the counter reaches TIMEOUT-1 and dmem_ack=0 on that edge, retire with exc=1, cause 11, RegWrite=0, drop req, go to IDLE. An ack on that same edge wins; no exception is raised.
- Only one outstanding access is allowed; a spurious ack while dmem_req=0 is ignored.
- mem_wb_valid is 0 in every cycle with no retirement; other mem_wb_* hold their last values.

Test Plan:
- Non-memory op: ex_alu_result=0x12345678, rd=5, RegWrite=1 -> next cycle mem_wb_valid=1, result=0x12345678, rd=5, no dmem_req.
- LB signed at addr 0x1003, ack on 3rd req cycle, rdata=0x80FF_FFFF -> ex_ready low 3 cycles, dmem_addr=0x1000, result=0xFFFFFF80. Repeat with LBU -> result=0x00000080.
- SH rs2=0x0000BEEF at addr 0x2002, zero-wait ack -> dmem_we=1, wstrb=1100, wdata=0xBEEFBEEF, req high exactly 1 cycle, retire 2 cycles after accept.
- LW at 0x3001 -> no req, mem_wb_exc=1, cause=01, RegWrite=0, result=0x3001. SW at 0x3002 -> cause=10.
- TIMEOUT=4, ack never arrives -> req high 4 cycles, then retire with cause=11, req=0. Repeat with ack in the 4th cycle -> normal retire, exc=0.
- rst asserted in the 2nd WAIT cycle, ack asserted 1 cycle later -> req=0 after the reset edge, no mem_wb_valid pulse, ex_ready=1.
